axi_stream_remove_header: RTL and testbench

- Downstream companion of the header-insert stage: strips a per-packet count of leading bytes from an AXI-Stream packet and re-packs the remainder into full-width beats.
- Byte order matches the insert stage: data[DATA_WD-1 -: 8] is the first byte on the wire, and keep is left-aligned (MSB-first, e.g. 1100 / 1110 on last beats).
- The strip count arrives on a separate valid/ready side channel, once per packet, before that packet's first beat is accepted.

---
 rtl/axi_stream_pkg.sv | 33 +++
 rtl/axi_stream_byte_shifter.sv | 24 ++
 rtl/axi_stream_remove_header.sv | 121 ++++++++++++
 tb/tb_axi_stream_remove_header.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - keep/count and byte-select helpers shared by the header insert/remove stages
package axi_stream_pkg;

  localparam int MAX_BYTES = 128;
  localparam int MAX_DATA  = MAX_BYTES * 8;

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_STREAM, ST_TAIL} rm_state_t;

  // Callers zero-extend their keep; the count is unaffected by the extra bits.
  function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) n += int'(keep[i]);
    return n;
  endfunction

  // n ones left-aligned within a w-bit keep (bits w-1 down to w-n).
  function automatic logic [MAX_BYTES-1:0] count_to_keep(input int n, input int w);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < w && i >= w - n) k[i] = 1'b1;
    return k;
  endfunction

  // Byte idx of an nbytes-wide word, byte 0 being the first on the wire (MSB end).
  function automatic logic [7:0] byte_at(input logic [MAX_DATA-1:0] data, input int nbytes,
                                         input int idx);
    if (idx >= 0 && idx < nbytes) return data[(nbytes-1-idx)*8 +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/axi_stream_byte_shifter.sv
// rtl/axi_stream_byte_shifter.sv - selects W bytes of {hold, next} from offset shift, zeroing past valid_cnt
module axi_stream_byte_shifter
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0] hold_data,
  input  logic [DATA_WD-1:0] next_data,
  input  logic [CNT_WD-1:0]  shift,
  input  logic [CNT_WD:0]    valid_cnt,
  output logic [DATA_WD-1:0] shifted
);

  always_comb begin
    shifted = '0;
    for (int j = 0; j < DATA_BYTE_WD; j++)
      if (j < int'(valid_cnt))
        shifted[(DATA_BYTE_WD-1-j)*8 +: 8] =
          byte_at(MAX_DATA'({hold_data, next_data}), 2*DATA_BYTE_WD, int'(shift) + j);
  end

endmodule

// File: rtl/axi_stream_remove_header.sv
// rtl/axi_stream_remove_header.sv - strips a per-packet count of leading bytes and re-packs full-width beats
module axi_stream_remove_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_strip,
  input  logic [CNT_WD-1:0]       strip_bytes,
  output logic                    ready_strip,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int N_WD = CNT_WD + 1;

  rm_state_t               state;
  logic [CNT_WD-1:0]       s;
  logic [DATA_WD-1:0]      hold;
  logic [N_WD-1:0]         n_hold;
  logic [N_WD-1:0]         n_in;
  logic [N_WD-1:0]         valid_cnt;
  logic [DATA_WD-1:0]      shifted;
  logic [DATA_BYTE_WD-1:0] keep_calc;
  logic                    out_free;
  logic                    tail_in;

  assign out_free    = !valid_out || ready_out;
  assign n_in        = N_WD'(keep_to_count(MAX_BYTES'(keep_in)));
  assign tail_in     = n_in > N_WD'(s);  // last beat still has bytes beyond s -> one more beat
  assign ready_strip = (state == ST_IDLE);
  assign ready_in    = (state == ST_FIRST) || (state == ST_STREAM && out_free);
  assign keep_calc   = DATA_BYTE_WD'(count_to_keep(int'(valid_cnt), DATA_BYTE_WD));

  always_comb begin
    valid_cnt = N_WD'(DATA_BYTE_WD);
    if (state == ST_TAIL)
      valid_cnt = n_hold - N_WD'(s);
    else if (last_in && !tail_in)
      valid_cnt = N_WD'(DATA_BYTE_WD) - N_WD'(s) + n_in;
  end

  axi_stream_byte_shifter #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .CNT_WD      (CNT_WD)
  ) u_shifter (
    .hold_data(hold),
    .next_data(data_in),
    .shift    (s),
    .valid_cnt(valid_cnt),
    .shifted  (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s         <= '0;
      hold      <= '0;
      n_hold    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_strip) begin
            s     <= strip_bytes;
            state <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (valid_in) begin
            hold   <= data_in;
            n_hold <= n_in;
            if (!last_in)     state <= ST_STREAM;
            else if (tail_in) state <= ST_TAIL;
            else              state <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (valid_in && out_free) begin
            valid_out <= 1'b1;
            data_out  <= shifted;
            keep_out  <= keep_calc;
            last_out  <= last_in && !tail_in;
            hold      <= data_in;
            n_hold    <= n_in;
            if (!last_in)     state <= ST_STREAM;
            else if (tail_in) state <= ST_TAIL;
            else              state <= ST_IDLE;
          end
        end
        ST_TAIL: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= shifted;
            keep_out  <= keep_calc;
            last_out  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb/tb_axi_stream_remove_header.sv - table-driven scoreboard bench for axi_stream_remove_header
module tb_axi_stream_remove_header;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_strip = 1'b0;
  logic [1:0]  strip_bytes = '0;
  logic        ready_strip;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  axi_stream_remove_header #(.DATA_WD(32), .DATA_BYTE_WD(4), .CNT_WD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_strip(valid_strip), .strip_bytes(strip_bytes), .ready_strip(ready_strip),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct { int s; int nbeats; int last_n; int bp; int exp_beats; } vec_t;

  beat_t exp_q[$];
  beat_t in_q[$];
  int    strip_q[$];
  int    tests = 0;
  int    fails = 0;
  int    bp_mode = 0;
  string tag = "init";
  vec_t  vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s/%s: got timeout/extra expected handshake", tag, name);
  endtask

  function automatic logic [3:0] keep_of(input int n);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[3-i] = 1'b1;
    return k;
  endfunction

  // Byte-stream model: concatenate valid bytes, drop s, re-chop into W-byte beats.
  task automatic build(input int s, input int nb, input int ln);
    logic [7:0] bytes[$];
    logic [7:0] v;
    beat_t bt;
    strip_q.push_back(s);
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      bt.last = (b == nb - 1);
      bt.keep = bt.last ? keep_of(ln) : 4'hF;
      for (int i = 0; i < W; i++) begin
        v = 8'(((b + 10) % 16) * 16 + i);
        if (bt.last && i >= ln) v = 8'h5A;
        else bytes.push_back(v);
        bt.data[31-8*i -: 8] = v;
      end
      in_q.push_back(bt);
    end
    for (int k = 0; k < s && bytes.size() > 0; k++) void'(bytes.pop_front());
    while (bytes.size() > 0) begin
      bt.data = '0;
      bt.keep = '0;
      for (int i = 0; i < W && bytes.size() > 0; i++) begin
        bt.data[31-8*i -: 8] = bytes.pop_front();
        bt.keep[3-i] = 1'b1;
      end
      bt.last = (bytes.size() == 0);
      exp_q.push_back(bt);
    end
  endtask

  task automatic drive_strip(input int s);
    int k;
    @(negedge clk);
    valid_strip = 1'b1;
    strip_bytes = 2'(s);
    for (k = 0; k < 100; k++) begin
      #1;
      if (ready_strip) break;
      @(negedge clk);
    end
    if (k == 100) fail_now("strip_timeout");
    else @(posedge clk);
    #1 valid_strip = 1'b0;
  endtask

  task automatic drive_beat(input beat_t bt);
    int k;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = bt.data;
    keep_in  = bt.keep;
    last_in  = bt.last;
    for (k = 0; k < 200; k++) begin
      #1;
      if (ready_in) break;
      @(negedge clk);
    end
    if (k == 200) fail_now("beat_timeout");
    else @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drive_all();
    beat_t bt;
    while (strip_q.size() > 0) begin
      drive_strip(strip_q.pop_front());
      do begin
        bt = in_q.pop_front();
        drive_beat(bt);
      end while (!bt.last && in_q.size() > 0);
    end
  endtask

  task automatic monitor(input int nexp, input bit chk_ready);
    int got, idle, cyc;
    beat_t e;
    bit stalled;
    logic [31:0] pd;
    logic [3:0] pk;
    got = 0; idle = 0; cyc = 0; stalled = 1'b0; pd = '0; pk = '0;
    while (idle < 12 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (bp_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = ~ready_out;
        default: ready_out = 1'($urandom_range(0, 1));
      endcase
      #2;
      if (stalled) begin
        check("stall_data", data_out, pd);
        check("stall_keep", keep_out, pk);
      end
      stalled = valid_out && !ready_out;
      if (stalled) begin
        pd = data_out;
        pk = keep_out;
        if (chk_ready) check("ready_in_stall", ready_in, 1'b0);
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) fail_now("extra_beat");
        else begin
          e = exp_q.pop_front();
          check($sformatf("data%0d", got), data_out, e.data);
          check($sformatf("keep%0d", got), keep_out, e.keep);
          check($sformatf("last%0d", got), last_out, e.last);
        end
        got++;
      end
      if (got >= nexp) idle++;
    end
    ready_out = 1'b1;
    check("beat_count", got, nexp);
  endtask

  initial begin
    beat_t bt;
    // {s, nbeats, last keep count, backpressure mode, expected output beats}
    vecs = '{'{1, 3, 2, 0, 3}, '{3, 3, 2, 0, 2}, '{0, 9, 3, 0, 9}, '{2, 1, 2, 0, 0},
             '{2, 1, 4, 0, 1}, '{1, 3, 2, 1, 3}, '{2, 5, 1, 2, 4}, '{3, 2, 4, 2, 2},
             '{0, 1, 1, 0, 1}, '{3, 2, 3, 0, 1}};

    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    check("valid_out", valid_out, 1'b0);
    check("data_out", data_out, 32'h0);
    check("keep_out", keep_out, 4'h0);
    check("last_out", last_out, 1'b0);
    check("ready_strip", ready_strip, 1'b1);
    check("ready_in", ready_in, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      tag = $sformatf("vec%0d", v);
      bp_mode = vecs[v].bp;
      build(vecs[v].s, vecs[v].nbeats, vecs[v].last_n);
      fork
        drive_all();
        monitor(vecs[v].exp_beats, 1'b1);
      join
      check("model_drained", exp_q.size(), 0);
      check("idle_ready_strip", ready_strip, 1'b1);
    end

    tag = "b2b";
    bp_mode = 2;
    build(1, 3, 2);
    build(2, 2, 4);
    fork
      drive_all();
      monitor(5, 1'b0);
    join
    check("model_drained", exp_q.size(), 0);

    // Reset while STREAM holds a valid output beat, then a clean packet.
    tag = "midreset";
    build(1, 3, 2);
    void'(strip_q.pop_front());
    ready_out = 1'b0;
    drive_strip(1);
    bt = in_q.pop_front();
    drive_beat(bt);
    bt = in_q.pop_front();
    drive_beat(bt);
    check("pre_valid", valid_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("valid_out", valid_out, 1'b0);
    check("data_out", data_out, 32'h0);
    check("keep_out", keep_out, 4'h0);
    check("last_out", last_out, 1'b0);
    exp_q.delete();
    in_q.delete();
    strip_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_out = 1'b1;
    bp_mode = 0;
    tag = "postreset";
    build(1, 3, 2);
    fork
      drive_all();
      monitor(3, 1'b1);
    join
    check("model_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
